sobel_window_gen: RTL

Streaming 3x3 window generator that sits directly upstream of the Sobel/Prewitt edge stage. It accepts an 8-bit greyscale image in raster order, one pixel per handshake, and buffers two image lines internally. For every interior pixel it emits the full 3x3 neighbourhood with valid/ready flow control. This replaces whole-frame memory indexing in the edge stage with a line-buffered stream.

---
 rtl/sobel_window_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a column shift register turn a
// raster pixel stream into one interior neighbourhood per accepted pixel.
module sobel_window_gen #(
    parameter int WIDTH  = 45,
    parameter int HEIGHT = 45
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [71:0]               win_out,
    output logic [$clog2(HEIGHT)-1:0] win_row,
    output logic [$clog2(WIDTH)-1:0]  win_col,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      frame_done,
    output logic [1:0]                state_dbg
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [7:0]    lb_newer [WIDTH];
    logic [7:0]    lb_older [WIDTH];
    logic [7:0]    lb_newer_rd, lb_older_rd;
    // Columns c-1 (index 0) and c (index 1); the incoming column completes the window.
    logic [7:0]    sr_top [2];
    logic [7:0]    sr_mid [2];
    logic [7:0]    sr_bot [2];
    logic          accept, last_col, complete;
    logic [71:0]   win_next;

    // Handshake: a pixel moves on the rising edge where pix_valid && pix_ready, and a
    // window moves where win_valid && win_ready; valid never depends on ready.
    assign pix_ready = (state != DONE) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (in_col == COL_LAST);
    assign complete  = accept && (in_row >= ROW_TWO) && (in_col >= COL_TWO);
    assign state_dbg = state;

    assign lb_newer_rd = lb_newer[in_col];
    assign lb_older_rd = lb_older[in_col];

    assign win_next = {pix_in,      sr_bot[1], sr_bot[0],
                       lb_newer_rd, sr_mid[1], sr_mid[0],
                       lb_older_rd, sr_top[1], sr_top[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            FILL: begin
                if (accept && last_col && (in_row == ROW_ONE)) state_next = STREAM;
            end
            STREAM: begin
                if (accept && last_col && (in_row == ROW_LAST)) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_col <= '0;
            in_row <= '0;
        end else if (state == DONE) begin
            in_col <= '0;
            in_row <= '0;
        end else if (accept) begin
            if (last_col) begin
                in_col <= '0;
                in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
            end else begin
                in_col <= in_col + 1'b1;
            end
        end
    end

    // Storage is never cleared: rows 0-1 and columns 0-1 of each frame overwrite it
    // before any window can be completed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_older[in_col] <= lb_newer_rd;
            lb_newer[in_col] <= pix_in;
            sr_top[0] <= sr_top[1];
            sr_top[1] <= lb_older_rd;
            sr_mid[0] <= sr_mid[1];
            sr_mid[1] <= lb_newer_rd;
            sr_bot[0] <= sr_bot[1];
            sr_bot[1] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
            win_out   <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (complete) begin
            win_valid <= 1'b1;
            win_out   <= win_next;
            win_row   <= in_row - 1'b1;
            win_col   <= in_col - 1'b1;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
